// File: rtl/instr_mem_prog.sv
// Writable instruction memory with a clear/load/run sequencer and registered,
// one-cycle-latency fetch port. Out-of-range fetches return NOP_WORD with a fault flag.
module instr_mem_prog #(
  parameter int unsigned         DATA_W   = 16,
  parameter int unsigned         ADDR_W   = 8,
  parameter int unsigned         DEPTH    = 256,
  parameter logic [DATA_W-1:0]   NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_done,
  input  logic              reload,
  output logic              prog_err,
  output logic              load_ready,
  output logic              running
);

  localparam int unsigned AW1   = ADDR_W + 1;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > (64'(1) << ADDR_W)) begin : g_bad_depth
    $error("instr_mem_prog: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_W");
  end

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   instr_q;
  logic                valid_q;
  logic                fault_q;
  logic                perr_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                pc_ok;
  logic                paddr_ok;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign pc_ok    = ({1'b0, pc} < AW1'(DEPTH));
  assign paddr_ok = ({1'b0, prog_addr} < AW1'(DEPTH));

  // Single write port shared by the clear sweep and program loading
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = prog_addr[IDX_W-1:0];
    mem_wdata = prog_data;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[IDX_W-1:0];
      mem_wdata = NOP_WORD;
    end else if (state_q == S_LOAD) begin
      mem_we    = prog_we && paddr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Sequencer and registered fetch response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        S_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            cnt_q   <= '0;
            state_q <= S_LOAD;
          end else begin
            cnt_q   <= cnt_q + ADDR_W'(1);
          end
        end
        S_LOAD: begin
          if (prog_we && !paddr_ok) begin
            perr_q <= 1'b1;
          end
          if (prog_done) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (fetch_en) begin
            valid_q <= 1'b1;
            if (pc_ok) begin
              instr_q <= mem[pc[IDX_W-1:0]];
            end else begin
              instr_q <= NOP_WORD;
              fault_q <= 1'b1;
            end
          end
          if (reload) begin
            state_q <= S_LOAD;
          end
        end
        default: begin
          state_q <= S_CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign prog_err    = perr_q;
  assign load_ready  = (state_q == S_LOAD);
  assign running     = (state_q == S_RUN);

endmodule

// File: tb/tb_instr_mem_prog.sv
// Scoreboard bench: two instances (DEPTH 16 and 13) share stimulus; expected
// fetch responses are queued with their due cycle and checked every cycle.
module tb_instr_mem_prog;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned DA = 16;
  localparam int unsigned DB = 13;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] pc;
  logic          fetch_en;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          prog_done;
  logic          reload;

  logic [DW-1:0] a_instr, b_instr;
  logic          a_valid, b_valid, a_fault, b_fault;
  logic          a_perr, b_perr, a_ready, b_ready, a_run, b_run;

  instr_mem_prog #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DA), .NOP_WORD(16'h0000)) u_a (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en),
    .instr(a_instr), .instr_valid(a_valid), .fault(a_fault),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_done(prog_done), .reload(reload), .prog_err(a_perr),
    .load_ready(a_ready), .running(a_run)
  );

  instr_mem_prog #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DB), .NOP_WORD(16'h0000)) u_b (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en),
    .instr(b_instr), .instr_valid(b_valid), .fault(b_fault),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_done(prog_done), .reload(reload), .prog_err(b_perr),
    .load_ready(b_ready), .running(b_run)
  );

  typedef struct packed {
    int unsigned   due;
    logic [DW-1:0] instr;
    logic          fault;
  } exp_t;

  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] mdl_a [DA];
  logic [DW-1:0] mdl_b [DB];
  int unsigned   cyc;
  int            n_checks;
  int            n_fail;
  bit            mon_en;
  bit            in_run;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Per-cycle response checker for both instances
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
        e = q_a.pop_front();
        check("a_valid", 32'(a_valid), 1);
        check("a_instr", 32'(a_instr), 32'(e.instr));
        check("a_fault", 32'(a_fault), 32'(e.fault));
      end else begin
        check("a_idle_valid", 32'(a_valid), 0);
        check("a_idle_fault", 32'(a_fault), 0);
      end
      if (q_b.size() > 0 && q_b[0].due == cyc) begin
        e = q_b.pop_front();
        check("b_valid", 32'(b_valid), 1);
        check("b_instr", 32'(b_instr), 32'(e.instr));
        check("b_fault", 32'(b_fault), 32'(e.fault));
      end else begin
        check("b_idle_valid", 32'(b_valid), 0);
        check("b_idle_fault", 32'(b_fault), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc = '0; fetch_en = 1'b0; prog_we = 1'b0; prog_addr = '0;
    prog_data = '0; prog_done = 1'b0; reload = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_a_instr"}, 32'(a_instr), 0);
    check({tag, "_a_valid"}, 32'(a_valid), 0);
    check({tag, "_a_fault"}, 32'(a_fault), 0);
    check({tag, "_a_perr"},  32'(a_perr),  0);
    check({tag, "_a_ready"}, 32'(a_ready), 0);
    check({tag, "_a_run"},   32'(a_run),   0);
    check({tag, "_b_instr"}, 32'(b_instr), 0);
    check({tag, "_b_valid"}, 32'(b_valid), 0);
    check({tag, "_b_fault"}, 32'(b_fault), 0);
    check({tag, "_b_perr"},  32'(b_perr),  0);
    check({tag, "_b_ready"}, 32'(b_ready), 0);
    check({tag, "_b_run"},   32'(b_run),   0);
  endtask

  task automatic enter_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    q_a.delete();
    q_b.delete();
    in_run = 1'b0;
    for (int i = 0; i < int'(DA); i++) mdl_a[i] = '0;
    for (int i = 0; i < int'(DB); i++) mdl_b[i] = '0;
  endtask

  // Releases reset, drives ignored junk during CLEAR, measures clear length
  task automatic release_and_clear(input string tag);
    int ra;
    int rb;
    ra = 0;
    rb = 0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    pc = 8'd3; fetch_en = 1'b1; prog_we = 1'b1; prog_addr = 8'd200;
    prog_data = 16'hDEAD; prog_done = 1'b1; reload = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i >= 10) idle_inputs();
      if (a_ready && ra == 0) ra = i;
      if (b_ready && rb == 0) rb = i;
      if (ra != 0) break;
    end
    idle_inputs();
    check({tag, "_a_clear_len"}, 32'(ra), DA);
    check({tag, "_b_clear_len"}, 32'(rb), DB);
    check({tag, "_a_perr"}, 32'(a_perr), 0);
    check({tag, "_b_perr"}, 32'(b_perr), 0);
    check({tag, "_b_run"},  32'(b_run),  0);
  endtask

  task automatic fetch(input logic [AW-1:0] addr, input bit rel);
    exp_t e;
    pc = addr; fetch_en = 1'b1; reload = rel;
    if (in_run) begin
      e.due = cyc + 1;
      e.instr = (int'(addr) < int'(DA)) ? mdl_a[int'(addr)] : 16'h0000;
      e.fault = (int'(addr) >= int'(DA));
      q_a.push_back(e);
      e.instr = (int'(addr) < int'(DB)) ? mdl_b[int'(addr)] : 16'h0000;
      e.fault = (int'(addr) >= int'(DB));
      q_b.push_back(e);
    end
    step();
    fetch_en = 1'b0; reload = 1'b0;
    if (rel) in_run = 1'b0;
  endtask

  task automatic prog_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit done);
    prog_we = 1'b1; prog_addr = addr; prog_data = data; prog_done = done;
    if (int'(addr) < int'(DA)) mdl_a[int'(addr)] = data;
    if (int'(addr) < int'(DB)) mdl_b[int'(addr)] = data;
    step();
    prog_we = 1'b0; prog_done = 1'b0;
    if (done) in_run = 1'b1;
  endtask

  task automatic go_run();
    prog_done = 1'b1;
    step();
    prog_done = 1'b0;
    in_run = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mon_en = 1'b0;
    idle_inputs();
    enter_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");

    release_and_clear("clr1");

    fetch(8'd5, 1'b0);
    check("load_a_ready", 32'(a_ready), 1);
    check("load_a_run",   32'(a_run),   0);
    go_run();
    check("run_a_run",   32'(a_run),   1);
    check("run_a_ready", 32'(a_ready), 0);
    check("run_b_run",   32'(b_run),   1);

    // Unprogrammed contents are NOP; b faults from 13 upward
    for (int i = 0; i < int'(DA); i++) fetch(AW'(i), 1'b0);
    fetch(8'd13, 1'b0);
    fetch(8'd12, 1'b0);
    fetch(8'd16, 1'b0);
    fetch(8'd255, 1'b0);
    fetch(8'd15, 1'b0);
    step();

    reload = 1'b1;
    step();
    reload = 1'b0;
    in_run = 1'b0;
    check("reload_a_ready", 32'(a_ready), 1);

    prog_write(8'd0, 16'h0210, 1'b0);
    prog_write(8'd1, 16'h4801, 1'b0);
    check("pre_err_a", 32'(a_perr), 0);
    check("pre_err_b", 32'(b_perr), 0);
    prog_write(8'd200, 16'h7777, 1'b0);
    check("err_a", 32'(a_perr), 1);
    check("err_b", 32'(b_perr), 1);
    prog_write(8'd14, 16'h1234, 1'b0);
    prog_write(8'd2, 16'hBEEF, 1'b1);
    check("done_a_run", 32'(a_run),  1);
    check("err_hold_a", 32'(a_perr), 1);

    fetch(8'd0, 1'b0);
    fetch(8'd1, 1'b0);
    fetch(8'd8, 1'b0);
    fetch(8'd2, 1'b0);
    fetch(8'd14, 1'b0);
    fetch(8'd13, 1'b0);
    fetch(8'd12, 1'b0);
    step();
    check("err_run_a", 32'(a_perr), 1);

    // Fetch together with reload: serviced once, then back in LOAD
    fetch(8'd1, 1'b1);
    check("rl_a_run",   32'(a_run),   0);
    check("rl_a_ready", 32'(a_ready), 1);
    check("rl_b_ready", 32'(b_ready), 1);
    step();
    step();
    prog_write(8'd0, 16'hABCD, 1'b1);
    fetch(8'd0, 1'b0);
    fetch(8'd1, 1'b0);
    step();

    // Reset from RUN, then again mid-CLEAR at counter 5
    #3;
    enter_reset();
    #1;
    chk_reset("rst_run");
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("mid_a_ready", 32'(a_ready), 0);
    #3;
    enter_reset();
    #1;
    chk_reset("rst_clr");
    step();
    release_and_clear("clr2");
    go_run();
    fetch(8'd0, 1'b0);
    fetch(8'd1, 1'b0);
    fetch(8'd13, 1'b0);
    step();
    step();

    check("q_a_empty", 32'(q_a.size()), 0);
    check("q_b_empty", 32'(q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
